sd_block_fetch: RTL

- Autonomous SD single-block read receiver, one stage downstream of the SPI byte engine in the CPLD.
- After the 68K sends CMD17 through the read-to-write window and is answered, it starts this block.
- The block clocks 0xFF bytes through the SPI engine, hunts for the start token, and streams 512 data bytes into the sector buffer RAM; the 68K later reads that RAM through the flash-read window.
- It captures the trailing CRC and reports DONE or ERROR status for the status register.

---
 rtl/sd_block_fetch_if.sv | 23 ++
 rtl/sd_block_fetch.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_fetch_if.sv
// SPI byte-engine and sector-buffer write signals used by sd_block_fetch.
// master: the fetch block; slave: the SPI engine plus buffer RAM side.
interface sd_block_fetch_if #(
  parameter int unsigned ADDR_W = 9
) ();
  logic              SPI_BUSY;
  logic [7:0]        SPI_RX;
  logic              SPI_GO;
  logic [7:0]        SPI_TX;
  logic              BUF_WE;
  logic [ADDR_W-1:0] BUF_ADDR;
  logic [7:0]        BUF_DATA;

  modport master (
    input  SPI_BUSY, SPI_RX,
    output SPI_GO, SPI_TX, BUF_WE, BUF_ADDR, BUF_DATA
  );

  modport slave (
    output SPI_BUSY, SPI_RX,
    input  SPI_GO, SPI_TX, BUF_WE, BUF_ADDR, BUF_DATA
  );
endinterface

// File: rtl/sd_block_fetch.sv
// Autonomous SD single-block read receiver: token hunt, 512-byte stream into the buffer, CRC capture.
// Optional SD_CRC_CHECK_EN adds a running CRC-16-CCITT check of the data against the received CRC.
module sd_block_fetch #(
  parameter int unsigned BLOCK_BYTES   = 512,
  parameter int unsigned ADDR_W        = 9,
  parameter int unsigned TOKEN_TIMEOUT = 4095
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET,
  input  logic                     START,
  input  logic                     ABORT,
  sd_block_fetch_if.master         fetch_if,
  output logic [15:0]              CRC,
  output logic                     ACTIVE,
  output logic                     DONE,
  output logic                     ERROR,
  output logic [1:0]               ERR_CODE
);

  typedef enum logic [3:0] {
    StIdle, StPGo, StPArm, StPWait, StDGo, StDArm, StDWait, StCGo, StCArm, StCWait, StFin
  } state_e;

  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(BLOCK_BYTES - 1);
  localparam logic [15:0]       PollLimit = 16'(TOKEN_TIMEOUT);

  state_e            state_q, state_d;
  logic [15:0]       poll_q, poll_d, poll_inc;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [15:0]       crc_q, crc_d;
  logic              crc_lo_q, crc_lo_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [1:0]        code_q, code_d;
  logic              spi_go, buf_we;
  logic              busy;
  logic [7:0]        rx;

`ifdef SD_CRC_CHECK_EN
  logic [15:0] calc_q, calc_d;

  // MSB-first CRC-16-CCITT over one byte, all eight bit-steps in one cycle.
  function automatic logic [15:0] crc16_byte(logic [15:0] c, logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction
`endif

  assign busy     = fetch_if.SPI_BUSY;
  assign rx       = fetch_if.SPI_RX;
  assign poll_inc = poll_q + 16'd1;

  always_comb begin
    state_d  = state_q;
    poll_d   = poll_q;
    cnt_d    = cnt_q;
    crc_d    = crc_q;
    crc_lo_d = crc_lo_q;
    done_d   = done_q;
    error_d  = error_q;
    code_d   = code_q;
`ifdef SD_CRC_CHECK_EN
    calc_d   = calc_q;
`endif
    spi_go   = 1'b0;
    buf_we   = 1'b0;
    if (ABORT) begin
      state_d = StIdle;
      done_d  = 1'b0;
      error_d = 1'b0;
      code_d  = 2'd0;
    end else begin
      unique case (state_q)
        StIdle, StFin: begin
          if (START) begin
            state_d  = StPGo;
            done_d   = 1'b0;
            error_d  = 1'b0;
            code_d   = 2'd0;
            poll_d   = 16'd0;
            cnt_d    = '0;
            crc_lo_d = 1'b0;
`ifdef SD_CRC_CHECK_EN
            calc_d   = 16'h0000;
`endif
          end
        end
        StPGo: if (!busy) begin spi_go = 1'b1; state_d = StPArm; end
        StPArm: state_d = StPWait;
        StPWait: begin
          if (!busy) begin
            if (rx == 8'hFE) begin
              state_d = StDGo;
            end else if (rx[7:4] == 4'h0) begin
              state_d = StFin;
              error_d = 1'b1;
              code_d  = 2'd2;
            end else begin
              // Anything else is idle line or noise and counts as a poll byte.
              poll_d = poll_inc;
              if (poll_inc == PollLimit) begin
                state_d = StFin;
                error_d = 1'b1;
                code_d  = 2'd1;
              end else begin
                state_d = StPGo;
              end
            end
          end
        end
        StDGo: if (!busy) begin spi_go = 1'b1; state_d = StDArm; end
        StDArm: state_d = StDWait;
        StDWait: begin
          if (!busy) begin
            buf_we = 1'b1;
`ifdef SD_CRC_CHECK_EN
            calc_d = crc16_byte(calc_q, rx);
`endif
            if (cnt_q == LastAddr) begin
              cnt_d   = '0;
              state_d = StCGo;
            end else begin
              cnt_d   = cnt_q + 1'b1;
              state_d = StDGo;
            end
          end
        end
        StCGo: if (!busy) begin spi_go = 1'b1; state_d = StCArm; end
        StCArm: state_d = StCWait;
        StCWait: begin
          if (!busy) begin
            if (!crc_lo_q) begin
              crc_d[15:8] = rx;
              crc_lo_d    = 1'b1;
              state_d     = StCGo;
            end else begin
              crc_d[7:0] = rx;
              state_d    = StFin;
`ifdef SD_CRC_CHECK_EN
              if ({crc_q[15:8], rx} != calc_q) begin
                error_d = 1'b1;
                code_d  = 2'd3;
              end else begin
                done_d  = 1'b1;
              end
`else
              done_d = 1'b1;
`endif
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q  <= StIdle;
      poll_q   <= 16'd0;
      cnt_q    <= '0;
      crc_q    <= 16'h0000;
      crc_lo_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      code_q   <= 2'd0;
`ifdef SD_CRC_CHECK_EN
      calc_q   <= 16'h0000;
`endif
    end else begin
      state_q  <= state_d;
      poll_q   <= poll_d;
      cnt_q    <= cnt_d;
      crc_q    <= crc_d;
      crc_lo_q <= crc_lo_d;
      done_q   <= done_d;
      error_q  <= error_d;
      code_q   <= code_d;
`ifdef SD_CRC_CHECK_EN
      calc_q   <= calc_d;
`endif
    end
  end

  // Strobes are gated by RESET so nothing leaves the block during the reset cycle.
  assign fetch_if.SPI_GO   = spi_go & ~RESET;
  assign fetch_if.SPI_TX   = 8'hFF;
  assign fetch_if.BUF_WE   = buf_we & ~RESET;
  assign fetch_if.BUF_ADDR = cnt_q;
  assign fetch_if.BUF_DATA = (buf_we & ~RESET) ? rx : 8'h00;

  assign CRC      = crc_q;
  assign ACTIVE   = (state_q != StIdle) && (state_q != StFin);
  assign DONE     = done_q;
  assign ERROR    = error_q;
  assign ERR_CODE = code_q;

endmodule
